// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with register-file write port, WB->ID operand
// bypass, and a retired-instruction counter.
module writeback_stage #(
  parameter int data_width = 32,
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [addr_width-1:0] in_dest,
  input  logic [data_width-1:0] in_alu_result,
  input  logic [data_width-1:0] in_mem_data,
  output logic [data_width-1:0] write_data,
  output logic [addr_width-1:0] write_address,
  output logic                  RegWrite,
  input  logic [addr_width-1:0] read_sel_1,
  input  logic [addr_width-1:0] read_sel_2,
  input  logic [data_width-1:0] rf_data_1,
  input  logic [data_width-1:0] rf_data_2,
  output logic [data_width-1:0] operand_1,
  output logic [data_width-1:0] operand_2,
  output logic [data_width-1:0] retired_count
);

  logic                  wb_valid;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [addr_width-1:0] wb_dest;
  logic [data_width-1:0] wb_alu;
  logic [data_width-1:0] wb_mem;
  logic                  retire;

  // The WB occupant leaves whenever the register is overwritten: either a
  // normal advance or a flush (which overrides stall) replacing it.
  assign retire = wb_valid && (!stall || flush);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dest       <= '0;
      wb_alu        <= '0;
      wb_mem        <= '0;
    end else if (!stall) begin
      wb_valid      <= in_valid;
      wb_reg_write  <= in_reg_write;
      wb_mem_to_reg <= in_mem_to_reg;
      wb_dest       <= in_dest;
      wb_alu        <= in_alu_result;
      wb_mem        <= in_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count <= '0;
    end else if (retire) begin
      retired_count <= retired_count + 1'b1;
    end
  end

  assign write_data    = wb_mem_to_reg ? wb_mem : wb_alu;
  assign write_address = wb_dest;
  assign RegWrite      = wb_valid && wb_reg_write && (wb_dest != '0);

  // The register file reads asynchronously but writes on the edge, so a
  // same-cycle read of the destination must take the in-flight value.
  assign operand_1 = (RegWrite && (write_address == read_sel_1)) ? write_data : rf_data_1;
  assign operand_2 = (RegWrite && (write_address == read_sel_2)) ? write_data : rf_data_2;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a random
// stream, with a scoreboard of expected register-file writes.
module tb_writeback_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int W  = AW + DW;
  localparam int SDW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, flush;
  logic          in_valid, in_reg_write, in_mem_to_reg;
  logic [AW-1:0] in_dest;
  logic [DW-1:0] in_alu_result, in_mem_data;
  logic [DW-1:0] write_data;
  logic [AW-1:0] write_address;
  logic          RegWrite;
  logic [AW-1:0] read_sel_1, read_sel_2;
  logic [DW-1:0] rf_data_1, rf_data_2;
  logic [DW-1:0] operand_1, operand_2;
  logic [DW-1:0] retired_count;

  // narrow instance used to reach the counter wrap quickly
  logic           s_valid;
  logic [SDW-1:0] s_write_data, s_operand_1, s_operand_2, s_count;
  logic [AW-1:0]  s_write_address;
  logic           s_reg_write_out;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic [DW-1:0] exp_count;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  writeback_stage #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_dest(in_dest), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .write_data(write_data), .write_address(write_address), .RegWrite(RegWrite),
    .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .operand_1(operand_1), .operand_2(operand_2), .retired_count(retired_count)
  );

  writeback_stage #(.data_width(SDW), .addr_width(AW)) dut_small (
    .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
    .in_valid(s_valid), .in_reg_write(1'b1), .in_mem_to_reg(1'b0),
    .in_dest(5'd1), .in_alu_result(4'd3), .in_mem_data(4'd0),
    .write_data(s_write_data), .write_address(s_write_address), .RegWrite(s_reg_write_out),
    .read_sel_1(5'd0), .read_sel_2(5'd0),
    .rf_data_1(4'd0), .rf_data_2(4'd0),
    .operand_1(s_operand_1), .operand_2(s_operand_2), .retired_count(s_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    stall = 0; flush = 0;
    in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0;
    in_dest = '0; in_alu_result = '0; in_mem_data = '0;
  endtask

  task automatic drive_instr(input logic v, input logic rw, input logic m2r,
                             input logic [AW-1:0] d, input logic [DW-1:0] alu,
                             input logic [DW-1:0] mem);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r;
    in_dest = d; in_alu_result = alu; in_mem_data = mem;
    if (v && rw && d != 0) exp_q.push_back({d, m2r ? mem : alu});
  endtask

  task automatic test_reset();
    drive_idle();
    s_valid = 0;
    read_sel_1 = 0; read_sel_2 = 0; rf_data_1 = 32'h11; rf_data_2 = 32'h22;
    rst = 1;
    in_valid = 1; in_reg_write = 1; in_dest = 5; in_alu_result = 32'h55;
    step(); step();
    checks++;
    if (RegWrite !== 1'b0 || write_address !== '0 || write_data !== '0)
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h, need 0/0/0", RegWrite, write_address, write_data);
    else passed++;
    checks++;
    if (retired_count !== '0 || s_count !== '0)
      $display("FAIL reset_count: got %0d/%0d, need 0", retired_count, s_count);
    else passed++;
    checks++;
    if (operand_1 !== 32'h11 || operand_2 !== 32'h22)
      $display("FAIL reset_operands: got %h/%h, need 11/22", operand_1, operand_2);
    else passed++;
    rst = 0;
    drive_idle();
    step();
    exp_count = 0;
  endtask

  task automatic test_alu_load();
    drive_instr(1, 1, 0, 5'd3, 32'h1234, 32'hDEAD);
    step();
    drive_instr(1, 1, 1, 5'd4, 32'h7777, 32'hBEEF);
    checks++;
    exp_w = exp_q.pop_front();
    if (!RegWrite || {write_address, write_data} !== exp_w)
      $display("FAIL alu_write: got we=%b %0d/%h, need 1 %0d/%h", RegWrite, write_address, write_data, exp_w[W-1:DW], exp_w[DW-1:0]);
    else passed++;
    step(); exp_count++;
    drive_idle();
    checks++;
    exp_w = exp_q.pop_front();
    if (!RegWrite || {write_address, write_data} !== exp_w)
      $display("FAIL load_write: got we=%b %0d/%h, need 1 %0d/%h", RegWrite, write_address, write_data, exp_w[W-1:DW], exp_w[DW-1:0]);
    else passed++;
    step(); exp_count++;
    checks++;
    if (RegWrite !== 1'b0 || retired_count !== exp_count)
      $display("FAIL alu_load_count: got we=%b count=%0d, need 0 %0d", RegWrite, retired_count, exp_count);
    else passed++;
  endtask

  task automatic test_r0();
    drive_instr(1, 1, 0, 5'd0, 32'hFFFF, 32'h0);
    step();
    drive_idle();
    read_sel_1 = 0; rf_data_1 = 0;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || operand_1 !== 32'h0)
      $display("FAIL r0_suppress: got we=%b op1=%h, need 0 0", RegWrite, operand_1);
    else passed++;
    step(); exp_count++;
    checks++;
    if (retired_count !== exp_count)
      $display("FAIL r0_count: got %0d, need %0d", retired_count, exp_count);
    else passed++;
  endtask

  task automatic test_bypass();
    drive_instr(1, 1, 0, 5'd7, 32'hA5A5, 32'h0);
    step();
    drive_idle();
    read_sel_1 = 7; read_sel_2 = 7; rf_data_1 = 70; rf_data_2 = 70;
    #1;
    checks++;
    if (operand_1 !== 32'hA5A5 || operand_2 !== 32'hA5A5)
      $display("FAIL bypass_both: got %h/%h, need a5a5/a5a5", operand_1, operand_2);
    else passed++;
    read_sel_1 = 8; rf_data_1 = 80;
    #1;
    checks++;
    if (operand_1 !== 32'd80 || operand_2 !== 32'hA5A5)
      $display("FAIL bypass_miss: got %0d/%h, need 80/a5a5", operand_1, operand_2);
    else passed++;
    checks++;
    exp_w = exp_q.pop_front();
    if ({write_address, write_data} !== exp_w)
      $display("FAIL bypass_write: got %0d/%h, need %0d/%h", write_address, write_data, exp_w[W-1:DW], exp_w[DW-1:0]);
    else passed++;
    step(); exp_count++;
  endtask

  task automatic test_stall_flush();
    drive_instr(1, 1, 0, 5'd9, 32'h99, 32'h0);
    step(); exp_count += 0;
    exp_w = exp_q.pop_front();
    stall = 1;
    in_dest = 10; in_alu_result = 32'h1010;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (!RegWrite || {write_address, write_data} !== exp_w || retired_count !== exp_count)
        $display("FAIL stall_hold%0d: got we=%b %0d/%h cnt=%0d, need 1 %0d/%h cnt=%0d", i,
                 RegWrite, write_address, write_data, retired_count, exp_w[W-1:DW], exp_w[DW-1:0], exp_count);
      else passed++;
    end
    flush = 1;
    step(); exp_count++;
    checks++;
    if (RegWrite !== 1'b0 || retired_count !== exp_count)
      $display("FAIL stall_flush: got we=%b cnt=%0d, need 0 %0d", RegWrite, retired_count, exp_count);
    else passed++;
    drive_idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] last_dest;
    logic [DW-1:0] last_data;
    logic          last_we;
    logic [DW-1:0] want;
    last_we = 0; last_dest = 0; last_data = 0;
    for (int i = 0; i < 40; i++) begin
      logic v, rw, m2r;
      logic [AW-1:0] d;
      logic [DW-1:0] a, m;
      v = 1'($urandom_range(0, 3) != 0);
      rw = 1'($urandom_range(0, 1));
      m2r = 1'($urandom_range(0, 1));
      d = AW'($urandom_range(0, 31));
      a = $urandom; m = $urandom;
      drive_instr(v, rw, m2r, d, a, m);
      read_sel_1 = AW'($urandom_range(0, 31));
      read_sel_2 = last_dest;
      rf_data_1 = $urandom; rf_data_2 = $urandom;
      #1;
      want = (last_we && read_sel_1 == last_dest) ? last_data : rf_data_1;
      checks++;
      if (operand_1 !== want)
        $display("FAIL b2b_op1_%0d: got %h, need %h", i, operand_1, want);
      else passed++;
      if (RegWrite) begin
        checks++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if ({write_address, write_data} !== exp_w)
          $display("FAIL b2b_write_%0d: got %0d/%h, need %0d/%h", i, write_address, write_data, exp_w[W-1:DW], exp_w[DW-1:0]);
        else passed++;
      end
      step();
      if (in_valid) exp_count++;
      last_we = v && rw && (d != 0);
      last_dest = d;
      last_data = m2r ? m : a;
    end
    drive_idle();
    if (RegWrite && exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if ({write_address, write_data} !== exp_w)
        $display("FAIL b2b_write_last: got %0d/%h, need %0d/%h", write_address, write_data, exp_w[W-1:DW], exp_w[DW-1:0]);
      else passed++;
    end
    step();
    checks++;
    if (retired_count !== exp_count || exp_q.size() != 0)
      $display("FAIL b2b_count: got %0d left=%0d, need %0d left=0", retired_count, exp_q.size(), exp_count);
    else passed++;
  endtask

  task automatic test_wrap();
    s_valid = 1;
    for (int i = 0; i < 16; i++) step();
    s_valid = 0;
    checks++;
    if (s_count !== 4'd15)
      $display("FAIL wrap_pre: got %0d, need 15", s_count);
    else passed++;
    step();
    checks++;
    if (s_count !== 4'd0)
      $display("FAIL wrap_zero: got %0d, need 0", s_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_load();
    test_r0();
    test_bypass();
    test_stall_flush();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
